rf_hazard_fwd: RTL and testbench
================================

Name: rf_hazard_fwd

Overview:
- Sits between the ID stage and the register file read ports.
- Tracks in-flight register writes in EX and MEM, selects a forwarded or register-file value for the rs/rt operands, and generates a stall on load-use and multi-cycle (mult/div) hazards.
- No WB-stage forwarding: the register file writes on the falling clock edge, so a WB write is readable by ID in the same cycle.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width
- MD_LAT, 4, EX occupancy in cycles of a multi-cycle op (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- RF_rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rsc, id_rtc  in  ADDR_W  source register addresses
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_rdc  in  ADDR_W  destination address
- id_wen  in  1  instruction writes id_rdc
- id_load  in  1  instruction is a load
- id_md  in  1  instruction is multi-cycle
- flush  in  1  kill ID instruction (taken branch)
- rf_rs, rf_rt  in  DATA_W  register file read data
- ex_result  in  DATA_W  EX-stage ALU result (current cycle)
- mem_result  in  DATA_W  MEM-stage ALU or load result (current cycle)
- fwd_rs, fwd_rt  out  DATA_W  selected operands
- sel_rs, sel_rt  out  2  0=RF, 1=EX, 2=MEM
- stall  out  1  hold PC and ID
- ex_bubble  out  1  insert NOP into EX this edge

Behaviour:
- Tags: ex_tag and mem_tag, each holding {v, rd, load, md}.
  - Tag is valid only if the instruction has wen=1 and rd≠0.
  - Reset clears all v, counter=0, state=RUN.
  - Post-reset outputs: stall=0, ex_bubble=0, sel=0, fwd=rf inputs.
- Operand match, per operand X∈{rs, rt}:
  - Match is active only if id_valid & id_use_X & Xc≠0.
  - EX match: ex_tag.v & ex_tag.rd==Xc.
  - MEM match: mem_tag.v & mem_tag.rd==Xc.
  - EX match has priority over MEM match.
- Operand select:
  - EX match with ex_tag.load=0 and ex_tag.md=0: fwd=ex_result, sel=1.
  - EX match with load or md set: hazard. sel=0 and fwd=rf; the value is ignored because stall=1.
  - Else MEM match: fwd=mem_result, sel=2.
  - Else: fwd=rf_X, sel=0.
  - All selection is combinational with zero latency.
- Hazard and stall:
  - luh = hazard on rs OR rt.
  - stall = luh | (state==BUSY).
  - ex_bubble = (luh | flush) & state==RUN.
- FSM states: RUN, BUSY.
  - RUN, edge with !stall:
    - ex_tag ← ID instruction, or invalid if flush/!id_valid.
    - mem_tag ← ex_tag.
    - If the instruction entering EX has id_md & MD_LAT>1: cnt←MD_LAT-1, →BUSY.
  - RUN, edge with luh: ex_tag ← invalid (bubble), mem_tag ← ex_tag; ID holds.
  - BUSY: ex_tag holds, mem_tag ← invalid, cnt decrements.
    - When cnt==1 on an edge: cnt←0, →RUN. The md instruction then advances on the next edge.
    - The md instruction remains EX-resident for MD_LAT cycles in total.
    - flush in BUSY is ignored (branches resolve before md issue).
- Dependency on md result: the ex_tag.md hazard holds while BUSY. On the final EX cycle (RUN, ex_tag.md still 1) the hazard also holds, so the consumer forwards from MEM one cycle later.
- Simultaneous flush & luh: bubble inserted, ID killed, stall=1 for that cycle. Upstream gives flush priority; this block does not latch the killed instruction.
- Reset mid-BUSY: immediate return to RUN, cnt=0, tags invalid, stall drops asynchronously.
- rd=0 writers are never tagged, so $0 is never forwarded or stalled on.

Test Plan:
- Reset: RF_rst=1 with arbitrary inputs → stall=0, sel_rs=sel_rt=0, fwd_rs=rf_rs.
- EX forward: add $3 then add $4,$3,$3 back-to-back; ex_result=0x55 → sel_rs=sel_rt=1, fwd_rs=fwd_rt=0x55, stall=0.
- MEM forward and priority:
  - Writer of $5, one independent instruction, then a reader of $5; mem_result=0xA0 → sel_rs=2, fwd_rs=0xA0.
  - With $5 also in EX → sel_rs=1.
- Load-use:
  - lw $6 followed by a $6 reader → one cycle stall=1, ex_bubble=1.
  - Next cycle: sel=2, fwd=mem_result=0x1234, stall=0.
- Multi-cycle with MD_LAT=4: md writing $7, then a $7 reader →
  - stall=1 for 4 cycles; mem_tag invalid for 3 of them;
  - reader then gets sel=2.
  - RF_rst mid-BUSY → stall=0 immediately.
- $0 and flush:
  - Writer of $0 followed by a $0 reader → sel=0, no stall.
  - flush with id_valid → ex_bubble=1, next-cycle ex_tag invalid, no forward.

Source files
------------

// File: rtl/rf_hazard_fwd.sv
// Operand forwarding and hazard detection between ID and the register file.
// Tracks EX/MEM destination tags and stalls on load-use and multi-cycle ops.
module rf_hazard_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              RF_rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rsc,
    input  logic [ADDR_W-1:0] id_rtc,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [ADDR_W-1:0] id_rdc,
    input  logic              id_wen,
    input  logic              id_load,
    input  logic              id_md,
    input  logic              flush,
    input  logic [DATA_W-1:0] rf_rs,
    input  logic [DATA_W-1:0] rf_rt,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] fwd_rs,
    output logic [DATA_W-1:0] fwd_rt,
    output logic [1:0]        sel_rs,
    output logic [1:0]        sel_rt,
    output logic              stall,
    output logic              ex_bubble
);

    localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              load;
        logic              md;
    } tag_t;

    typedef enum logic {RUN, BUSY} state_t;

    state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    tag_t       ex_reg, ex_next;
    tag_t       mem_reg, mem_next;

    logic [ADDR_W-1:0] src [2];
    logic              use_src [2];
    logic [DATA_W-1:0] rf_val [2];

    assign src[0]     = id_rsc;
    assign src[1]     = id_rtc;
    assign use_src[0] = id_use_rs;
    assign use_src[1] = id_use_rt;
    assign rf_val[0]  = rf_rs;
    assign rf_val[1]  = rf_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_op
            logic              act;
            logic              m_ex;
            logic              m_mem;
            logic              haz;
            logic [DATA_W-1:0] fwd_op;
            logic [1:0]        sel_op;

            assign act   = id_valid && use_src[gi] && (src[gi] != '0);
            assign m_ex  = act && ex_reg.v && (ex_reg.rd == src[gi]);
            assign m_mem = act && mem_reg.v && (mem_reg.rd == src[gi]);
            assign haz   = m_ex && (ex_reg.load || ex_reg.md);

            // A hazard keeps the RF value; it is never consumed because stall is high.
            always_comb begin
                fwd_op = rf_val[gi];
                sel_op = 2'd0;
                if (m_ex) begin
                    if (!haz) begin
                        fwd_op = ex_result;
                        sel_op = 2'd1;
                    end
                end else if (m_mem) begin
                    fwd_op = mem_result;
                    sel_op = 2'd2;
                end
            end
        end
    endgenerate

    logic luh;
    assign luh       = gen_op[0].haz || gen_op[1].haz;
    assign stall     = luh || (state_reg == BUSY);
    assign ex_bubble = (luh || flush) && (state_reg == RUN);
    assign fwd_rs    = gen_op[0].fwd_op;
    assign fwd_rt    = gen_op[1].fwd_op;
    assign sel_rs    = gen_op[0].sel_op;
    assign sel_rt    = gen_op[1].sel_op;

    always_ff @(posedge clk or posedge RF_rst) begin
        if (RF_rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            ex_reg    <= '0;
            mem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ex_reg    <= ex_next;
            mem_reg   <= mem_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ex_next    = ex_reg;
        mem_next   = mem_reg;
        case (state_reg)
            RUN: begin
                mem_next = ex_reg;
                if (luh || flush || !id_valid) begin
                    ex_next = '0;
                end else begin
                    ex_next.v    = id_wen && (id_rdc != '0);
                    ex_next.rd   = id_rdc;
                    ex_next.load = id_load;
                    ex_next.md   = id_md;
                    if (id_md && (MD_LAT > 1)) begin
                        cnt_next   = CNT_INIT;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // The md op stays in EX; nothing new reaches MEM meanwhile.
                mem_next = '0;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_hazard_fwd.sv
// Directed bench for rf_hazard_fwd: forwarding, priority, load-use, md stall,
// $0 handling, flush and asynchronous reset.
module tb_rf_hazard_fwd;

    logic        clk;
    logic        RF_rst;
    logic        id_valid;
    logic [4:0]  id_rsc, id_rtc, id_rdc;
    logic        id_use_rs, id_use_rt, id_wen, id_load, id_md;
    logic        flush;
    logic [31:0] rf_rs, rf_rt, ex_result, mem_result;
    logic [31:0] fwd_rs, fwd_rt;
    logic [1:0]  sel_rs, sel_rt;
    logic        stall, ex_bubble;

    int n_checks = 0;
    int n_fail   = 0;

    rf_hazard_fwd #(.DATA_W(32), .ADDR_W(5), .MD_LAT(4)) dut (
        .clk(clk), .RF_rst(RF_rst), .id_valid(id_valid),
        .id_rsc(id_rsc), .id_rtc(id_rtc), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rdc(id_rdc), .id_wen(id_wen), .id_load(id_load), .id_md(id_md),
        .flush(flush), .rf_rs(rf_rs), .rf_rt(rf_rt),
        .ex_result(ex_result), .mem_result(mem_result),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .sel_rs(sel_rs), .sel_rt(sel_rt),
        .stall(stall), .ex_bubble(ex_bubble)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present one ID instruction; outputs are checked #1 later, mid-cycle.
    task automatic issue(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic wen, input logic ld, input logic md, input logic fl);
        id_valid  = v;
        id_rsc    = rs;
        id_use_rs = urs;
        id_rtc    = rt;
        id_use_rt = urt;
        id_rdc    = rd;
        id_wen    = wen;
        id_load   = ld;
        id_md     = md;
        flush     = fl;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        RF_rst     = 1'b1;
        rf_rs      = 32'h111;
        rf_rt      = 32'h222;
        ex_result  = 32'h55;
        mem_result = 32'hA0;
        issue(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 1, 1, 0);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_bubble", {31'd0, ex_bubble}, 32'd0);
        check("rst_sel_rs", {30'd0, sel_rs}, 32'd0);
        check("rst_sel_rt", {30'd0, sel_rt}, 32'd0);
        check("rst_fwd_rs", fwd_rs, 32'h111);
        next_cycle();
        RF_rst = 1'b0;

        // EX forwarding: add $3 ; add $4,$3,$3
        issue(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
        check("first_sel_rs", {30'd0, sel_rs}, 32'd0);
        next_cycle();
        issue(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0);
        check("ex_sel_rs", {30'd0, sel_rs}, 32'd1);
        check("ex_sel_rt", {30'd0, sel_rt}, 32'd1);
        check("ex_fwd_rs", fwd_rs, 32'h55);
        check("ex_fwd_rt", fwd_rt, 32'h55);
        check("ex_stall", {31'd0, stall}, 32'd0);
        next_cycle();

        // MEM forwarding: writer $5, independent $10, reader/writer of $5
        issue(1, 5'd8, 1, 5'd9, 1, 5'd5, 1, 0, 0, 0);
        next_cycle();
        issue(1, 5'd11, 1, 5'd12, 1, 5'd10, 1, 0, 0, 0);
        next_cycle();
        issue(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0);
        check("mem_sel_rs", {30'd0, sel_rs}, 32'd2);
        check("mem_fwd_rs", fwd_rs, 32'hA0);
        check("mem_sel_rt", {30'd0, sel_rt}, 32'd0);
        check("mem_fwd_rt", fwd_rt, 32'h222);
        next_cycle();
        // EX=$5, MEM=$10
        issue(1, 5'd5, 1, 5'd10, 1, 5'd5, 1, 0, 0, 0);
        check("ex5_sel_rs", {30'd0, sel_rs}, 32'd1);
        check("mem10_sel_rt", {30'd0, sel_rt}, 32'd2);
        check("mem10_fwd_rt", fwd_rt, 32'hA0);
        next_cycle();
        // EX=$5 and MEM=$5: EX wins
        issue(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        check("prio_sel_rs", {30'd0, sel_rs}, 32'd1);
        check("prio_fwd_rs", fwd_rs, 32'h55);
        next_cycle();

        // Load-use: lw $6 ; reader of $6 (writes $9)
        issue(1, 5'd1, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0);
        check("lw_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        issue(1, 5'd6, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0);
        check("luh_stall", {31'd0, stall}, 32'd1);
        check("luh_bubble", {31'd0, ex_bubble}, 32'd1);
        check("luh_sel_rs", {30'd0, sel_rs}, 32'd0);
        check("luh_fwd_rs", fwd_rs, 32'h111);
        next_cycle();
        mem_result = 32'h1234;
        #1;
        check("lu2_stall", {31'd0, stall}, 32'd0);
        check("lu2_bubble", {31'd0, ex_bubble}, 32'd0);
        check("lu2_sel_rs", {30'd0, sel_rs}, 32'd2);
        check("lu2_fwd_rs", fwd_rs, 32'h1234);
        next_cycle();

        // Multi-cycle: md $7 ; reader of $7 (rt=$9 probes MEM tag)
        mem_result = 32'h77;
        issue(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1, 0);
        check("md_issue_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        issue(1, 5'd7, 1, 5'd9, 1, 5'd0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("md_stall_c%0d", c), {31'd0, stall}, 32'd1);
            check($sformatf("md_sel_rt_c%0d", c), {30'd0, sel_rt}, (c == 0) ? 32'd2 : 32'd0);
            check($sformatf("md_bubble_c%0d", c), {31'd0, ex_bubble}, (c == 3) ? 32'd1 : 32'd0);
            next_cycle();
            #1;
        end
        check("md_done_stall", {31'd0, stall}, 32'd0);
        check("md_done_sel_rs", {30'd0, sel_rs}, 32'd2);
        check("md_done_fwd_rs", fwd_rs, 32'h77);
        next_cycle();

        // Reset while BUSY
        issue(1, 5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1, 0);
        next_cycle();
        issue(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        check("busy_stall", {31'd0, stall}, 32'd1);
        RF_rst = 1'b1;
        #1;
        check("rst_busy_stall", {31'd0, stall}, 32'd0);
        check("rst_busy_sel_rs", {30'd0, sel_rs}, 32'd0);
        @(negedge clk);
        RF_rst = 1'b0;
        #1;
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        next_cycle();

        // $0: load to $0 then reader of $0
        issue(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);
        next_cycle();
        issue(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        check("r0_sel_rs", {30'd0, sel_rs}, 32'd0);
        check("r0_sel_rt", {30'd0, sel_rt}, 32'd0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        next_cycle();

        // Flush: killed writer of $8 must not be forwarded
        issue(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 0, 0, 1);
        check("fl_bubble", {31'd0, ex_bubble}, 32'd1);
        check("fl_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        issue(1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        check("fl_sel_rs", {30'd0, sel_rs}, 32'd0);
        check("fl_fwd_rs", fwd_rs, 32'h111);
        check("fl_next_bubble", {31'd0, ex_bubble}, 32'd0);
        next_cycle();

        // Flush together with load-use
        issue(1, 5'd1, 1, 5'd0, 0, 5'd11, 1, 1, 0, 0);
        next_cycle();
        issue(1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1);
        check("flluh_stall", {31'd0, stall}, 32'd1);
        check("flluh_bubble", {31'd0, ex_bubble}, 32'd1);
        next_cycle();
        issue(1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        check("flluh_sel_rs", {30'd0, sel_rs}, 32'd2);
        check("flluh_after_stall", {31'd0, stall}, 32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
